mux16_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single 1-bit output of a 16:1 multiplexer among 16 requesters. It drives the mux select from an internal grant FSM and enforces a bounded hold time per grant so that no requester can starve the others. It presents the selected data bit with a valid flag. It sits directly in front of the existing `mux16to1` datapath and sequences its `sel` input.

---
 rtl/mux_ctrl_pkg.sv | 32 +++
 rtl/mux16to1.sv | 10 +
 rtl/mux16_rr_arbiter.sv | 90 +++++++++
 tb/tb_mux16_rr_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared types and the round-robin pick helper for the mux16 arbiter.
package mux_ctrl_pkg;

    localparam int N     = 16;
    localparam int SEL_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan downwards so the last hit is the requester closest to ptr.
    function automatic pick_t rr_pick(input logic [N-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux16to1.sv
// 16:1 single-bit data multiplexer shared by the arbitrated requesters.
module mux16to1 (
    input  logic [3:0]  sel,
    input  logic [15:0] in,
    output logic        y
);

    assign y = in[sel];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin grant FSM with bounded hold, sequencing the select of mux16to1.
//   state    | meaning
//   ST_IDLE  | no grant; arbitrate from ptr on the next edge
//   ST_GRANT | grant held until req[sel] drops or hold limit reached
module mux16_rr_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int N        = 16,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     in,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             valid
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_e           state_q,    state_d;
    logic [SEL_W-1:0] ptr_q,      ptr_d;
    logic [SEL_W-1:0] sel_q,      sel_d;
    logic [N-1:0]     grant_q,    grant_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    pick_t            pick;
    logic             mux_y;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        hold_cnt_d = hold_cnt_q;
        pick       = rr_pick(req, ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    sel_d      = pick.idx;
                    grant_d    = N'(1) << pick.idx;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Drop and hold expiry collapse into one release.
                if (!req[sel_q] || hold_cnt_q == HC_W'(MAX_HOLD - 1)) begin
                    grant_d    = '0;
                    ptr_d      = sel_q + SEL_W'(1);
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            grant_q    <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    mux16to1 u_mux (
        .sel (sel_q),
        .in  (in),
        .y   (mux_y)
    );

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = |grant_q;
    assign y     = mux_y & valid;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Random and directed stimulus on four arbiters (hold 8/4/2/3) against a queue-free behavioural model.
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] in;

    logic [15:0] grant_w [4];
    logic [3:0]  sel_w   [4];
    logic        y_w     [4];
    logic        valid_w [4];

    int n_chk = 0;
    int n_bad = 0;

    // Model state: who owns the mux, for how many cycles, and where the scan starts.
    bit m_act  [4];
    int m_own  [4];
    int m_held [4];
    int m_ptr  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mux16_rr_arbiter #(
            .N        (16),
            .SEL_W    (4),
            .MAX_HOLD ((g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 2 : 3)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req),
            .in    (in),
            .grant (grant_w[g]),
            .sel   (sel_w[g]),
            .y     (y_w[g]),
            .valid (valid_w[g])
        );
    end

    function automatic int hold_of(int g);
        case (g)
            0:       return 8;
            1:       return 4;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 4; g++) begin
            m_act[g]  = 1'b0;
            m_own[g]  = 0;
            m_held[g] = 0;
            m_ptr[g]  = 0;
        end
    endtask

    task automatic model_step();
        if (rst_n) begin
            for (int g = 0; g < 4; g++) begin
                if (!m_act[g]) begin
                    if (req != 16'h0) begin
                        for (int k = 0; k < 16; k++) begin
                            if (req[(m_ptr[g] + k) % 16]) begin
                                m_own[g] = (m_ptr[g] + k) % 16;
                                break;
                            end
                        end
                        m_act[g]  = 1'b1;
                        m_held[g] = 1;
                    end
                end else if (!req[m_own[g]] || m_held[g] == hold_of(g)) begin
                    m_act[g] = 1'b0;
                    m_ptr[g] = (m_own[g] + 1) % 16;
                end else begin
                    m_held[g]++;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] eg;
        for (int g = 0; g < 4; g++) begin
            eg = m_act[g] ? (16'h1 << m_own[g]) : 16'h0;
            chk($sformatf("%s_grant%0d", tag, g), 32'(grant_w[g]), 32'(eg));
            chk($sformatf("%s_sel%0d", tag, g), 32'(sel_w[g]), 32'(m_own[g]));
            chk($sformatf("%s_valid%0d", tag, g), 32'(valid_w[g]), 32'(m_act[g]));
            chk($sformatf("%s_y%0d", tag, g), 32'(y_w[g]), 32'(m_act[g] && in[m_own[g]]));
        end
    endtask

    task automatic cycle(input logic [15:0] r, input logic [15:0] d);
        @(negedge clk);
        req = r;
        in  = d;
        #1 check_all("neg");
        @(posedge clk);
        model_step();
        #1 check_all("pos");
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst");
    endtask

    task automatic release_reset(input logic [15:0] r, input logic [15:0] d);
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        in    = d;
        @(posedge clk);
        model_step();
        #1 check_all("rel");
    endtask

    initial begin
        logic [15:0] r;
        logic        pv;
        int          nxt;
        int          last;

        rst_n = 1'b0;
        req   = 16'hFFFF;
        in    = 16'hB338;
        model_reset();
        #1 check_all("por");
        chk("por_grant", 32'(grant_w[0]), 32'h0);
        chk("por_y", 32'(y_w[0]), 32'h0);

        // Release with everyone requesting: port 0 wins on the first edge.
        release_reset(16'hFFFF, 16'hB338);
        chk("first_grant", 32'(grant_w[0]), 32'h0001);

        // Single requester 5 for three cycles.
        assert_reset();
        release_reset(16'h0000, 16'hB338);
        cycle(16'h0020, 16'hB338);
        chk("single_grant", 32'(grant_w[0]), 32'h0020);
        chk("single_y", 32'(y_w[0]), 32'h1);
        cycle(16'h0020, 16'hB338);
        cycle(16'h0020, 16'hB338);
        cycle(16'h0000, 16'hB338);
        chk("single_rel", 32'(valid_w[0]), 32'h0);
        cycle(16'h0040, 16'hB338);
        chk("single_ptr6", 32'(sel_w[0]), 32'h6);

        // Saturation: instance 1 (hold 4) must walk 0..15 and wrap to 0.
        assert_reset();
        release_reset(16'h0000, 16'h0000);
        pv  = 1'b0;
        nxt = 0;
        for (int c = 0; c < 86; c++) begin
            cycle(16'hFFFF, 16'($urandom));
            if (valid_w[1] && !pv) begin
                chk("sat_order", 32'(sel_w[1]), 32'(nxt % 16));
                nxt++;
            end
            pv = valid_w[1];
        end
        chk("sat_count", 32'(nxt), 32'd18);

        // Fairness: instance 2 (hold 2) alternates between 3 and 9.
        assert_reset();
        release_reset(16'h0000, 16'h0000);
        pv   = 1'b0;
        last = -1;
        for (int c = 0; c < 20; c++) begin
            cycle(16'h0208, 16'($urandom));
            if (valid_w[2] && !pv) begin
                chk("fair_alt", 32'(sel_w[2]), (last == 3) ? 32'd9 : 32'd3);
                last = int'(sel_w[2]);
            end
            pv = valid_w[2];
        end

        // Mid-grant reset clears immediately and restarts the scan at 0.
        assert_reset();
        release_reset(16'h0000, 16'hFFFF);
        cycle(16'h0400, 16'hFFFF);
        cycle(16'h0400, 16'hFFFF);
        assert_reset();
        chk("midrst_grant", 32'(grant_w[0]), 32'h0);
        chk("midrst_valid", 32'(valid_w[0]), 32'h0);
        chk("midrst_y", 32'(y_w[0]), 32'h0);
        release_reset(16'h0401, 16'hFFFF);
        chk("midrst_ptr0", 32'(grant_w[0]), 32'h0001);

        // Drop of req[7] coinciding with expiry on instance 3 (hold 3).
        assert_reset();
        release_reset(16'h0000, 16'h0080);
        cycle(16'h0080, 16'h0080);
        cycle(16'h0080, 16'h0080);
        cycle(16'h0080, 16'h0080);
        chk("coin_held", 32'(grant_w[3]), 32'h0080);
        cycle(16'h0000, 16'h0080);
        chk("coin_rel", 32'(valid_w[3]), 32'h0);
        cycle(16'h0000, 16'h0080);
        chk("coin_gap", 32'(valid_w[3]), 32'h0);
        cycle(16'h0180, 16'h0080);
        chk("coin_ptr8", 32'(grant_w[3]), 32'h0100);

        // Random traffic with occasional mid-flight resets.
        assert_reset();
        release_reset(16'h0000, 16'h0000);
        r = 16'h0;
        for (int c = 0; c < 1500; c++) begin
            case ($urandom_range(0, 4))
                0:       r = 16'h0;
                1:       r = 16'h1 << $urandom_range(0, 15);
                2:       r = 16'($urandom);
                default: r = r;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                assert_reset();
                release_reset(r, 16'($urandom));
            end else begin
                cycle(r, 16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
